// File: rtl/huffman_merge_ctrl.sv
// Huffman merge sequencer: runs the external sort once per pass, merges the two
// smallest lanes and emits one merge record per pass until a single node remains.
module huffman_merge_ctrl #(
  parameter int W_W          = 13,
  parameter int N_NODE       = 10,
  parameter int SORT_TIMEOUT = 1023
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      start,
  input  logic [N_NODE*W_W-1:0]     FREQ_IN,
  output logic                      sort_begin,
  output logic [N_NODE*W_W-1:0]     SORT_IN,
  input  logic                      sort_over,
  input  logic [N_NODE*W_W-1:0]     SORT_OUT,
  output logic                      merge_valid,
  input  logic                      merge_ready,
  output logic [W_W-1:0]            merge_a,
  output logic [W_W-1:0]            merge_b,
  output logic [W_W-1:0]            merge_sum,
  output logic [$clog2(N_NODE)-1:0] merge_idx,
  output logic                      busy,
  output logic                      done,
  output logic [W_W-1:0]            root_weight,
  output logic                      error
);

  localparam int IDX_W = $clog2(N_NODE);
  localparam int TO_W  = $clog2(SORT_TIMEOUT + 1);
  localparam logic [W_W-1:0] EMPTY = '1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_GO,
    S_WAIT,
    S_CHECK,
    S_EMIT,
    S_MERGE,
    S_DONE,
    S_ERR
  } state_t;

  state_t                     state, state_next;
  logic [N_NODE-1:0][W_W-1:0] work;
  logic [N_NODE-1:0][W_W-1:0] freq_load;
  logic                       in_ovf;
  logic [W_W:0]               sum_wide;
  logic                       sum_ovf;
  logic                       sort_over_q;
  logic                       sort_rise;
  logic [TO_W-1:0]            to_cnt;

  // Unused symbols become EMPTY so they sort behind every real weight.
  always_comb begin
    freq_load = '0;
    in_ovf    = 1'b0;
    for (int k = 0; k < N_NODE; k++) begin
      freq_load[k] = (FREQ_IN[k*W_W +: W_W] == '0) ? EMPTY : FREQ_IN[k*W_W +: W_W];
      if (FREQ_IN[k*W_W +: W_W] == EMPTY) in_ovf = 1'b1;
    end
  end

  assign sum_wide  = {1'b0, work[0]} + {1'b0, work[1]};
  assign sum_ovf   = (sum_wide >= {1'b0, EMPTY});
  assign sort_rise = sort_over & ~sort_over_q;
  assign merge_a   = work[0];
  assign merge_b   = work[1];
  assign merge_sum = sum_wide[W_W-1:0];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    sort_begin  = 1'b0;
    merge_valid = 1'b0;
    busy        = 1'b1;
    error       = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        busy  = 1'b0;
        error = (state == S_ERR);
        if (start) state_next = in_ovf ? S_ERR : S_LOAD;
      end
      S_LOAD: state_next = S_GO;
      S_GO: begin
        sort_begin = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (sort_rise)                                state_next = S_CHECK;
        else if (to_cnt == TO_W'(SORT_TIMEOUT - 1))   state_next = S_ERR;
      end
      S_CHECK: begin
        if (work[0] == EMPTY || work[1] == EMPTY) state_next = S_DONE;
        else                                      state_next = S_EMIT;
      end
      // An overflowing sum never reaches the consumer.
      S_EMIT: begin
        if (sum_ovf) begin
          state_next = S_ERR;
        end else begin
          merge_valid = 1'b1;
          if (merge_ready) state_next = S_MERGE;
        end
      end
      S_MERGE: state_next = S_LOAD;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      work        <= '0;
      SORT_IN     <= '0;
      to_cnt      <= '0;
      sort_over_q <= 1'b0;
      merge_idx   <= '0;
      root_weight <= '0;
      done        <= 1'b0;
    end else begin
      sort_over_q <= sort_over;
      done        <= (state_next == S_DONE) && (state != S_DONE);
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            work        <= freq_load;
            merge_idx   <= '0;
            root_weight <= '0;
          end
        end
        S_LOAD: SORT_IN <= work;
        S_GO:   to_cnt  <= '0;
        S_WAIT: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (sort_rise) work <= SORT_OUT;
        end
        S_CHECK: begin
          if (work[1] == EMPTY) root_weight <= (work[0] == EMPTY) ? '0 : work[0];
        end
        // The parent replaces the smaller child; the other lane is retired.
        S_MERGE: begin
          work[0]   <= sum_wide[W_W-1:0];
          work[1]   <= EMPTY;
          merge_idx <= merge_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_merge_ctrl.sv
// Bench for huffman_merge_ctrl: behavioural sort model, vector table and a
// scoreboard of expected merge records built from a reference Huffman model.
module tb_huffman_merge_ctrl;

  localparam int W_W    = 13;
  localparam int N_NODE = 10;
  localparam int VW     = N_NODE * W_W;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          start;
  logic [VW-1:0] FREQ_IN;
  logic          sort_begin;
  logic [VW-1:0] SORT_IN;
  logic          sort_over;
  logic [VW-1:0] SORT_OUT;
  logic          merge_valid;
  logic          merge_ready;
  logic [12:0]   merge_a, merge_b, merge_sum;
  logic [3:0]    merge_idx;
  logic          busy, done, error;
  logic [12:0]   root_weight;

  huffman_merge_ctrl #(.W_W(W_W), .N_NODE(N_NODE), .SORT_TIMEOUT(1023)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .FREQ_IN(FREQ_IN),
    .sort_begin(sort_begin), .SORT_IN(SORT_IN), .sort_over(sort_over), .SORT_OUT(SORT_OUT),
    .merge_valid(merge_valid), .merge_ready(merge_ready),
    .merge_a(merge_a), .merge_b(merge_b), .merge_sum(merge_sum), .merge_idx(merge_idx),
    .busy(busy), .done(done), .root_weight(root_weight), .error(error)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [VW-1:0] freq;
    int            mode;
    int            stall_idx;
    int            start_idx;
    int            reset_idx;
    logic          exp_error;
    logic [12:0]   exp_root;
  } vec_t;

  typedef struct packed {
    logic [12:0] a;
    logic [12:0] b;
    logic [12:0] sum;
    logic [3:0]  idx;
  } rec_t;

  rec_t exp_q[$];
  int   exp_passes;
  bit   exp_immediate;
  int   n_vec = 0;
  int   n_err = 0;
  int   sort_mode = 0;
  vec_t tbl[14];

  function automatic logic [VW-1:0] pack10(input int v0, v1, v2, v3, v4, v5, v6, v7, v8, v9);
    int v[10];
    logic [VW-1:0] r;
    v = '{v0, v1, v2, v3, v4, v5, v6, v7, v8, v9};
    r = '0;
    for (int k = 0; k < 10; k++) r[k*W_W +: W_W] = 13'(v[k]);
    return r;
  endfunction

  function automatic vec_t mkvec(input logic [VW-1:0] f, input int m, st, si, ri,
                                 input logic e, input int root);
    vec_t t;
    t.freq = f; t.mode = m; t.stall_idx = st; t.start_idx = si; t.reset_idx = ri;
    t.exp_error = e; t.exp_root = 13'(root);
    return t;
  endfunction

  // Sort model: mode 0 answers with a clean edge, mode 1 never answers,
  // mode 2 holds sort_over high beforehand and shows junk until its fresh edge.
  initial begin
    int sm[$];
    logic [VW-1:0] sorted;
    sort_over = 1'b0;
    SORT_OUT  = '0;
    forever begin
      @(negedge CLK);
      if (sort_begin && sort_mode != 1) begin
        sm.delete();
        for (int k = 0; k < N_NODE; k++) sm.push_back(int'(SORT_IN[k*W_W +: W_W]));
        sm.sort();
        for (int k = 0; k < N_NODE; k++) sorted[k*W_W +: W_W] = 13'(sm[k]);
        if (sort_mode == 0) begin
          repeat (2) @(negedge CLK);
          SORT_OUT  = sorted;
          sort_over = 1'b1;
          @(negedge CLK);
          sort_over = 1'b0;
        end else begin
          repeat (3) @(negedge CLK);
          sort_over = 1'b0;
          @(negedge CLK);
          SORT_OUT  = sorted;
          sort_over = 1'b1;
        end
      end else if (!sort_begin) begin
        if (sort_mode == 2) begin
          sort_over = 1'b1;
          SORT_OUT  = '0;
        end else begin
          sort_over = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference Huffman schedule: repeatedly merge the two smallest weights.
  task automatic buildExpect(input logic [VW-1:0] freq, input int mode);
    int v[$];
    int s;
    int k;
    rec_t r;
    exp_q.delete();
    exp_passes    = 0;
    exp_immediate = 0;
    k = 0;
    for (int i = 0; i < N_NODE; i++) begin
      if (int'(freq[i*W_W +: W_W]) == 8191) exp_immediate = 1;
      if (freq[i*W_W +: W_W] != '0) v.push_back(int'(freq[i*W_W +: W_W]));
    end
    if (exp_immediate) return;
    if (mode == 1) begin
      exp_passes = 1;
      return;
    end
    forever begin
      exp_passes++;
      v.sort();
      if (v.size() < 2) return;
      s = v[0] + v[1];
      if (s >= 8191) return;
      r.a = 13'(v[0]); r.b = 13'(v[1]); r.sum = 13'(s); r.idx = 4'(k);
      exp_q.push_back(r);
      void'(v.pop_front());
      void'(v.pop_front());
      v.push_front(s);
      k++;
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    int   cycles = 0;
    int   passes = 0;
    int   stall_cnt = 0;
    bit   finished = 0;
    bit   aborted = 0;
    rec_t r;
    buildExpect(t.freq, t.mode);
    sort_mode = t.mode;
    repeat (3) @(negedge CLK);
    FREQ_IN = t.freq;
    start   = 1'b1;
    @(negedge CLK);
    start   = 1'b0;
    FREQ_IN = pack10(1, 2, 3, 4, 5, 6, 7, 8, 9, 11);
    checkOutput("busy after start", busy, !exp_immediate);
    checkOutput("error after start", error, exp_immediate);
    while (!finished && cycles < 3000) begin
      if (sort_begin) passes++;
      if (merge_valid && !merge_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected record", {merge_a, merge_b, merge_sum, merge_idx}, '0);
          finished = 1;
        end else if (t.reset_idx == int'(merge_idx)) begin
          nRST = 1'b0;
          #1;
          checkOutput("rst valid", merge_valid, 0);
          checkOutput("rst merge fields", {merge_a, merge_b, merge_sum, merge_idx}, 0);
          checkOutput("rst status", {busy, done, error, sort_begin}, 0);
          checkOutput("rst root", root_weight, 0);
          checkOutput("rst SORT_IN", SORT_IN, 0);
          @(negedge CLK);
          nRST = 1'b1;
          exp_q.delete();
          finished = 1;
          aborted  = 1;
        end else if (t.stall_idx == int'(merge_idx) && stall_cnt < 20) begin
          r = exp_q[0];
          checkOutput("stall hold", {merge_valid, merge_a, merge_b, merge_sum, merge_idx}, {1'b1, r});
          stall_cnt++;
        end else begin
          r = exp_q.pop_front();
          checkOutput($sformatf("merge %0d", r.idx), {merge_a, merge_b, merge_sum, merge_idx}, r);
          merge_ready = 1'b1;
          if (t.start_idx == int'(merge_idx)) begin
            start   = 1'b1;
            FREQ_IN = pack10(100, 200, 0, 0, 0, 0, 0, 0, 0, 0);
          end
        end
      end else begin
        merge_ready = 1'b0;
        start       = 1'b0;
        if (done || error) finished = 1;
      end
      if (!finished) begin
        @(negedge CLK);
        cycles++;
      end
    end
    merge_ready = 1'b0;
    start       = 1'b0;
    if (aborted) return;
    if (!finished) begin
      checkOutput("cycle budget", finished, 1);
      return;
    end
    checkOutput("error flag", error, t.exp_error);
    checkOutput("busy at end", busy, 0);
    checkOutput("records left", exp_q.size(), 0);
    checkOutput("sort passes", passes, exp_passes);
    if (t.mode == 1) checkOutput("timeout length", (cycles >= 1020 && cycles <= 1030), 1);
    if (!t.exp_error) begin
      checkOutput("done pulse", done, 1);
      checkOutput("root", root_weight, t.exp_root);
      @(negedge CLK);
      checkOutput("done width", done, 0);
      checkOutput("root hold", root_weight, t.exp_root);
    end
  endtask

  initial begin
    logic [VW-1:0] t3;
    nRST        = 1'b0;
    start       = 1'b0;
    merge_ready = 1'b0;
    FREQ_IN     = '0;
    t3 = pack10(16, 0, 5, 45, 0, 12, 9, 0, 13, 0);

    tbl[0]  = mkvec('0, 0, -1, -1, -1, 0, 0);
    tbl[1]  = mkvec(pack10(0, 0, 0, 7, 0, 0, 0, 0, 0, 0), 0, -1, -1, -1, 0, 7);
    tbl[2]  = mkvec(t3, 0, -1, -1, -1, 0, 100);
    tbl[3]  = mkvec(t3, 0, 2, -1, -1, 0, 100);
    tbl[4]  = mkvec(t3, 1, -1, -1, -1, 1, 0);
    tbl[5]  = mkvec(pack10(2048, 0, 2048, 0, 4096, 0, 0, 0, 0, 0), 0, -1, -1, -1, 1, 0);
    tbl[6]  = mkvec(pack10(0, 4095, 0, 0, 0, 0, 0, 0, 4095, 0), 0, -1, -1, -1, 0, 8190);
    tbl[7]  = mkvec(pack10(4095, 4096, 0, 0, 0, 0, 0, 0, 0, 0), 0, -1, -1, -1, 1, 0);
    tbl[8]  = mkvec(pack10(3, 8191, 4, 0, 0, 0, 0, 0, 0, 0), 0, -1, -1, -1, 1, 0);
    tbl[9]  = mkvec(pack10(10, 3, 7, 1, 9, 2, 8, 4, 6, 5), 0, -1, -1, -1, 0, 55);
    tbl[10] = mkvec(pack10(0, 0, 0, 7, 0, 0, 0, 0, 0, 0), 2, -1, -1, -1, 0, 7);
    tbl[11] = mkvec(t3, 0, -1, 1, -1, 0, 100);
    tbl[12] = mkvec(t3, 0, -1, -1, 2, 0, 0);
    tbl[13] = mkvec(t3, 0, -1, -1, -1, 0, 100);

    repeat (3) @(negedge CLK);
    checkOutput("reset status", {busy, done, error, merge_valid, sort_begin}, 0);
    checkOutput("reset merge fields", {merge_a, merge_b, merge_sum, merge_idx}, 0);
    checkOutput("reset root", root_weight, 0);
    checkOutput("reset SORT_IN", SORT_IN, 0);
    nRST = 1'b1;

    for (int i = 0; i < 14; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(tbl[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
